// File: rtl/cpu_board_pkg.sv
// Shared definitions for the board-side CPU step controller: instruction
// constants, display-select codes, debounce states and the seven-segment font.
package cpu_board_pkg;

  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

  typedef enum logic [1:0] {
    SEL_PC    = 2'b00,
    SEL_IR    = 2'b01,
    SEL_MDR   = 2'b10,
    SEL_WDATA = 2'b11
  } disp_sel_e;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_PRESS_WAIT,
    DB_HELD,
    DB_RELEASE_WAIT
  } db_state_e;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is returned dark and gated by the caller.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] seg;
    seg = 8'hFF;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Synchronizes a raw push-button and debounces it, emitting exactly one
// one-cycle press pulse per accepted press regardless of hold time.
module key_debouncer
  import cpu_board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_key_meta;
  logic          r_key_sync;
  db_state_e     r_state;
  logic [CW-1:0] r_cnt;
  logic          r_press;
  logic [CW-1:0] w_cnt_inc;
  logic          w_cnt_done;

  assign w_cnt_inc  = r_cnt + CW'(1);
  assign w_cnt_done = (w_cnt_inc == CW'(DEBOUNCE_CYCLES));
  assign press      = r_press;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, which is what makes the two-stage synchronizer a real delay line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_meta <= 1'b0;
      r_key_sync <= 1'b0;
    end else begin
      r_key_meta <= key_raw;
      r_key_sync <= r_key_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= DB_IDLE;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      unique case (r_state)
        DB_IDLE: begin
          if (r_key_sync) begin
            r_state <= DB_PRESS_WAIT;
            r_cnt   <= '0;
          end
        end
        DB_PRESS_WAIT: begin
          if (!r_key_sync) begin
            r_state <= DB_IDLE;
          end else if (w_cnt_done) begin
            r_press <= 1'b1;
            r_state <= DB_HELD;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        DB_HELD: begin
          if (!r_key_sync) begin
            r_state <= DB_RELEASE_WAIT;
            r_cnt   <= '0;
          end
        end
        DB_RELEASE_WAIT: begin
          // Any high sample while releasing is bounce, not a new press.
          if (r_key_sync) begin
            r_state <= DB_HELD;
          end else if (w_cnt_done) begin
            r_state <= DB_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: r_state <= DB_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Board step controller: turns STEP/RUN into a one-cycle CPU advance strobe,
// halts free-run on EBREAK and scans a selected CPU word onto 8 hex digits.
module cpu_step_ctrl
  import cpu_board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RUN_DIV         = 8,
  parameter int SCAN_DIV        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_step,
  input  logic        sw_run,
  input  logic [1:0]  sw_sel,
  input  logic [31:0] pc_in,
  input  logic [31:0] ir_in,
  input  logic [31:0] mdr_in,
  input  logic [31:0] wdata_in,
  output logic        step_en,
  output logic [15:0] step_cnt,
  output logic        halted,
  output logic [31:0] disp_word,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_code
);

  localparam int DW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic          r_run_meta;
  logic          r_run_sync;
  logic [DW-1:0] r_div;
  logic          r_halted;
  logic [15:0]   r_step_cnt;
  logic [31:0]   r_disp_word;
  logic [SW-1:0] r_scan_cnt;
  logic [2:0]    r_digit;
  logic [7:0]    r_seg_code;

  logic          w_press;
  logic          w_div_term;
  logic          w_run_fall;
  logic          w_step_en;
  logic [31:0]   w_disp_next;
  logic [3:0]    w_nibble;
  logic [7:0]    w_font;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debouncer (
    .clk    (clk),
    .rst    (rst),
    .key_raw(key_step),
    .press  (w_press)
  );

  assign w_div_term = (r_div == DW'(RUN_DIV - 1));
  // Falls in the same edge that the synchronized RUN level drops to 0.
  assign w_run_fall = r_run_sync & ~r_run_meta;
  assign w_step_en  = r_run_sync ? (~r_halted & w_div_term) : w_press;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run_meta <= 1'b0;
      r_run_sync <= 1'b0;
      r_div      <= '0;
      r_halted   <= 1'b0;
      r_step_cnt <= '0;
    end else begin
      r_run_meta <= sw_run;
      r_run_sync <= r_run_meta;

      if (r_run_sync && !r_halted) begin
        r_div <= w_div_term ? '0 : r_div + DW'(1);
      end else begin
        r_div <= '0;
      end

      if (w_run_fall) begin
        r_halted <= 1'b0;
      end else if (w_step_en && r_run_sync && (ir_in == EBREAK_INSN)) begin
        r_halted <= 1'b1;
      end

      if (w_step_en && (r_step_cnt != 16'hFFFF)) begin
        r_step_cnt <= r_step_cnt + 16'd1;
      end
    end
  end

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the case can leave it holding a value and infer a latch.
  always_comb begin
    w_disp_next = pc_in;
    unique case (disp_sel_e'(sw_sel))
      SEL_PC:    w_disp_next = pc_in;
      SEL_IR:    w_disp_next = ir_in;
      SEL_MDR:   w_disp_next = mdr_in;
      SEL_WDATA: w_disp_next = wdata_in;
      default:   w_disp_next = pc_in;
    endcase
  end

  assign w_nibble = r_disp_word[{r_digit, 2'b00} +: 4];
  assign w_font   = hex_to_seg(w_nibble);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_disp_word <= '0;
      r_scan_cnt  <= '0;
      r_digit     <= '0;
      r_seg_code  <= 8'hC0;
    end else begin
      r_disp_word <= w_disp_next;
      if (r_scan_cnt == SW'(SCAN_DIV - 1)) begin
        r_scan_cnt <= '0;
        r_digit    <= r_digit + 3'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + SW'(1);
      end
      // dp is active-low and marks the halt only on the rightmost digit.
      r_seg_code <= {~(r_halted && (r_digit == 3'd0)), w_font[6:0]};
    end
  end

  assign step_en   = w_step_en;
  assign step_cnt  = r_step_cnt;
  assign halted    = r_halted;
  assign disp_word = r_disp_word;
  assign seg_an    = ~(8'b1 << r_digit);
  assign seg_code  = r_seg_code;

endmodule
